m_serial_sub: RTL and testbench

Bit-serial 32-bit subtractor, LSB-first, one bit per clock. It is the inverse-operation companion of the bit-serial adder in the supersmall datapath.
- Computes rslt = rrs - rrt with two shift registers and a single borrow flop.
- Adds a start/busy/done handshake and borrow/zero flags so a controller can sequence it.

---
 rtl/m_serial_sub_pkg.sv | 13 +
 rtl/m_serial_sub_if.sv | 28 ++
 rtl/m_serial_sub_fsub_bit.sv | 14 +
 rtl/m_serial_sub.sv | 80 ++++++++
 tb/tb_m_serial_sub.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/m_serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor.
// State encodings and the default datapath width.
package m_serial_sub_pkg;

  localparam int P_W_DEF = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/m_serial_sub_if.sv
// Controller-facing bundle of the bit-serial subtractor.
// The controller owns start/operands; the unit owns results and flags.
interface m_serial_sub_if #(
  parameter int P_W = 32
);

  logic           w_start;
  logic [P_W-1:0] w_rrs;
  logic [P_W-1:0] w_rrt;
  logic [P_W-1:0] w_rslt;
  logic           w_borrow;
  logic           w_zero;
  logic           w_busy;
  logic           w_done;

  modport master (
    output w_start, w_rrs, w_rrt,
    input  w_rslt, w_borrow, w_zero,
    input  w_busy, w_done
  );

  modport slave (
    input  w_start, w_rrs, w_rrt,
    output w_rslt, w_borrow, w_zero,
    output w_busy, w_done
  );

endinterface

// File: rtl/m_serial_sub_fsub_bit.sv
// One-bit full subtractor: d = a - b - bin.
// Borrow-out is set when a is too small to cover b plus bin.
module m_fsub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/m_serial_sub.sv
// Bit-serial LSB-first subtractor, one bit per clock.
// Start/busy/done handshake with borrow and zero flags.
module m_serial_sub
  import m_serial_sub_pkg::*;
#(
  parameter int P_W  = P_W_DEF,
  parameter int P_CW = 6
) (
  input  logic w_clk,
  input  logic w_rst,
  m_serial_sub_if.slave bus
);

  state_t          st;
  logic [P_W-1:0]  a;
  logic [P_W-1:0]  b;
  logic            bw;
  logic            vld;
  logic [P_CW-1:0] cnt;
  logic            d;
  logic            bout;
  logic            take;
  logic            last;

  m_fsub_bit u_bit (
    .a    (a[0]),
    .b    (b[0]),
    .bin  (bw),
    .d    (d),
    .bout (bout)
  );

  assign take = bus.w_start &&
                (st == ST_IDLE || st == ST_DONE);
  assign last = (cnt == P_CW'(P_W - 1));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      st  <= ST_IDLE;
      a   <= '0;
      b   <= '0;
      bw  <= 1'b0;
      cnt <= '0;
      vld <= 1'b0;
    end else begin
      case (st)
        ST_RUN: begin
          a   <= {d, a[P_W-1:1]};
          b   <= {1'b0, b[P_W-1:1]};
          bw  <= bout;
          cnt <= cnt + 1'b1;
          if (last) begin
            st  <= ST_DONE;
            vld <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start
          if (take) begin
            a   <= bus.w_rrs;
            b   <= bus.w_rrt;
            bw  <= 1'b0;
            cnt <= '0;
            st  <= ST_RUN;
          end else begin
            st  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // flags stay low until a first result exists
  assign bus.w_rslt   = a;
  assign bus.w_borrow = vld & bw;
  assign bus.w_zero   = vld & ~|a;
  assign bus.w_busy   = (st == ST_RUN);
  assign bus.w_done   = (st == ST_DONE);

endmodule

// File: tb/tb_m_serial_sub.sv
// Randomized self-checking bench for m_serial_sub.
// Results are compared with plain (rrs - rrt) arithmetic.
module tb_m_serial_sub;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  m_serial_sub_if #(.P_W(32)) bus ();

  m_serial_sub #(.P_W(32), .P_CW(6)) u_dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag,
                         input logic [31:0] x,
                         input logic [31:0] y);
    logic [31:0] r;
    r = x - y;
    chk({tag, " rslt"}, bus.w_rslt, r);
    chk({tag, " borrow"}, 32'(bus.w_borrow),
        32'(x < y));
    chk({tag, " zero"}, 32'(bus.w_zero),
        32'(r == 32'd0));
  endtask

  task automatic run_op(input logic [31:0] x,
                        input logic [31:0] y,
                        input string tag);
    int n;
    @(negedge clk);
    bus.w_start = 1'b1;
    bus.w_rrs   = x;
    bus.w_rrt   = y;
    @(negedge clk);
    bus.w_start = 1'b0;
    bus.w_rrs   = $urandom;
    bus.w_rrt   = $urandom;
    n = 0;
    while (bus.w_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy"}, n, 32);
    chk({tag, " done"}, 32'(bus.w_done), 32'd1);
    chk_res(tag, x, y);
    @(negedge clk);
    chk({tag, " done1"}, 32'(bus.w_done), 32'd0);
  endtask

  task automatic b2b_test();
    logic [31:0] x1, y1, x2, y2;
    int n;
    x1 = $urandom; y1 = $urandom;
    x2 = $urandom; y2 = $urandom;
    @(negedge clk);
    bus.w_start = 1'b1;
    bus.w_rrs   = x1;
    bus.w_rrt   = y1;
    repeat (5) @(negedge clk);
    bus.w_rrs   = x2;
    bus.w_rrt   = y2;
    n = 0;
    while (!bus.w_done && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("b2b done", 32'(bus.w_done), 32'd1);
    chk_res("b2b first", x1, y1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.w_done && n < 40);
    chk("b2b period", n, 33);
    bus.w_start = 1'b0;
    chk_res("b2b second", x2, y2);
    @(negedge clk);
    chk("b2b idle done", 32'(bus.w_done), 32'd0);
    chk("b2b idle busy", 32'(bus.w_busy), 32'd0);
  endtask

  task automatic rst_test();
    int seen;
    @(negedge clk);
    bus.w_start = 1'b1;
    bus.w_rrs   = $urandom;
    bus.w_rrt   = $urandom;
    @(negedge clk);
    bus.w_start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst rslt", bus.w_rslt, 32'd0);
    chk("rst borrow", 32'(bus.w_borrow), 32'd0);
    chk("rst zero", 32'(bus.w_zero), 32'd0);
    chk("rst busy", 32'(bus.w_busy), 32'd0);
    chk("rst done", 32'(bus.w_done), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.w_done) seen++;
    end
    chk("rst no done", seen, 0);
    run_op(32'd100, 32'd58, "100-58");
  endtask

  initial begin
    logic [31:0] x, y;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.w_start = 1'b0;
    bus.w_rrs   = '0;
    bus.w_rrt   = '0;
    repeat (2) @(negedge clk);
    chk("init rslt", bus.w_rslt, 32'd0);
    chk("init zero", 32'(bus.w_zero), 32'd0);
    chk("init borrow", 32'(bus.w_borrow), 32'd0);
    chk("init busy", 32'(bus.w_busy), 32'd0);
    chk("init done", 32'(bus.w_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("pre zero", 32'(bus.w_zero), 32'd0);

    run_op(32'd7, 32'd6, "7-6");
    run_op(32'd6, 32'd7, "6-7");
    run_op(32'h1234_5678, 32'h1234_5678, "eq");
    run_op(32'd0, 32'd1, "0-1");
    run_op(32'hFFFF_FFFF, 32'd0, "max-0");

    b2b_test();
    rst_test();

    for (int i = 0; i < 200; i++) begin
      x = $urandom;
      y = (i % 17 == 0) ? x : 32'($urandom);
      run_op(x, y, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
